vga_scan_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_scan_counter.sv | 84 ++++++++
 rtl/vga_scan_controller.sv | 147 ++++++++++++++
 tb/tb_vga_scan_controller.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA scan path:
//   - rgb12_t     : packed {R,G,B} colour, 4 bits per channel
//   - VGA_*       : 640x480 @ 60 Hz timing defaults (25 MHz pixel clock)
//   - total4()    : sums the four segments of a line or frame
//   - bar_colour(): colour-bar lookup used by the optional test pattern
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int unsigned VGA_H_ACTIVE = 32'd640;
  localparam int unsigned VGA_H_FP     = 32'd16;
  localparam int unsigned VGA_H_SYNC   = 32'd96;
  localparam int unsigned VGA_H_BP     = 32'd48;
  localparam int unsigned VGA_V_ACTIVE = 32'd480;
  localparam int unsigned VGA_V_FP     = 32'd10;
  localparam int unsigned VGA_V_SYNC   = 32'd2;
  localparam int unsigned VGA_V_BP     = 32'd33;

  // Length of a line or frame from its active/porch/sync segments.
  function automatic int unsigned total4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  localparam int unsigned VGA_H_TOTAL = total4(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int unsigned VGA_V_TOTAL = total4(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  // Colour bars: index bit 2 -> red, bit 1 -> green, bit 0 -> blue, full scale.
  function automatic rgb12_t bar_colour(input logic [2:0] idx);
    rgb12_t col;
    case (idx)
      3'd0:    col = rgb12_t'(12'h000);
      3'd1:    col = rgb12_t'(12'h00F);
      3'd2:    col = rgb12_t'(12'h0F0);
      3'd3:    col = rgb12_t'(12'h0FF);
      3'd4:    col = rgb12_t'(12'hF00);
      3'd5:    col = rgb12_t'(12'hF0F);
      3'd6:    col = rgb12_t'(12'hFF0);
      3'd7:    col = rgb12_t'(12'hFFF);
      default: col = rgb12_t'(12'h000);
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// -----------------------------------------------------------------------------
// vga_scan_counter
// Free-running raster counters plus stage-0 timing decode.
// Ports:
//   clk_i, reset_i   pixel clock, synchronous active-high reset
//   h_cnt_o, v_cnt_o current column / row
//   act0_o           counters inside the visible area
//   hs0_o, vs0_o     sync levels for the current position (active low)
//   frame0_o         counters sit at (0,0)
// -----------------------------------------------------------------------------
module vga_scan_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned HW       = $clog2(total4(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int unsigned VW       = $clog2(total4(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          act0_o,
  output logic          hs0_o,
  output logic          vs0_o,
  output logic          frame0_o
);

  localparam int unsigned H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 32'd1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 32'd1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 32'd1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 32'd1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  // Next position: column wraps every line, row advances only on that wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  // Position registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign act0_o   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs0_o    = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
  assign vs0_o    = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  assign frame0_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scan_controller.sv
// -----------------------------------------------------------------------------
// vga_scan_controller
// Raster-scan initiator: issues pxl_x/pxl_y to the sprite drawers, takes their
// registered colour/Drawing response one cycle later and drives the VGA pins.
// Coordinate to pins is two cycles; sync is delayed the same amount.
// Ports:
//   clk, reset                         pixel clock, synchronous active-high reset
//   pxl_x, pxl_y                       scan coordinate (zero-extended)
//   Red_level/Green_level/Blue_level   drawer colour (one cycle after coordinate)
//   Drawing                            drawer hit (same timing as colour)
//   bg_rgb                             background colour {R,G,B}
//   vga_r, vga_g, vga_b                DAC outputs (black in blanking)
//   hsync, vsync                       active-low syncs
//   frame_start                        one-cycle pulse per frame
//   test_mode                          colour-bar override, only when the
//                                      VGA_TEST_PATTERN_EN macro is defined
// -----------------------------------------------------------------------------
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pxl_x,
  output logic [31:0] pxl_y,
  input  logic [3:0]  Red_level,
  input  logic [3:0]  Green_level,
  input  logic [3:0]  Blue_level,
  input  logic        Drawing,
  input  logic [11:0] bg_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic        test_mode
`endif
);

  localparam int unsigned HW = $clog2(total4(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VW = $clog2(total4(V_ACTIVE, V_FP, V_SYNC, V_BP));

  logic [HW-1:0] h_cnt_s;
  logic [VW-1:0] v_cnt_s;
  logic          act0_s, hs0_s, vs0_s, frame0_s;

  vga_scan_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_counter (
    .clk_i    (clk),
    .reset_i  (reset),
    .h_cnt_o  (h_cnt_s),
    .v_cnt_o  (v_cnt_s),
    .act0_o   (act0_s),
    .hs0_o    (hs0_s),
    .vs0_o    (vs0_s),
    .frame0_o (frame0_s)
  );

  assign pxl_x = {{(32 - HW){1'b0}}, h_cnt_s};
  assign pxl_y = {{(32 - VW){1'b0}}, v_cnt_s};

  logic   act1_q, hs1_q, vs1_q;
  rgb12_t rgb_q, rgb_d;
  logic   hsync_q, vsync_q, frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar1_q;

  // Column bits picking the bar, aligned with the drawer response.
  always_ff @(posedge clk) begin
    if (reset) begin
      bar1_q <= 3'd0;
    end else begin
      bar1_q <= pxl_x[8:6];
    end
  end
`endif

  // Stage 1: delay decode one cycle to meet the drawers' registered response.
  // Sync flags rest at the inactive (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      act1_q <= act0_s;
      hs1_q  <= hs0_s;
      vs1_q  <= vs0_s;
    end
  end

  // Colour mux: blanking beats everything, then bars, then drawer, then bg.
  always_comb begin
    rgb_d = '0;
    if (!act1_q) begin
      rgb_d = '0;
    end
`ifdef VGA_TEST_PATTERN_EN
    else if (test_mode) begin
      rgb_d = bar_colour(bar1_q);
    end
`endif
    else if (Drawing) begin
      rgb_d = '{r: Red_level, g: Green_level, b: Blue_level};
    end else begin
      rgb_d = rgb12_t'(bg_rgb);
    end
  end

  // Output registers: RGB and syncs leave together; frame_start follows (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      hsync_q       <= hs1_q;
      vsync_q       <= vs1_q;
      frame_start_q <= frame0_s;
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_controller
// Two instances share clock, reset and drawer inputs: dut_a uses 640x480
// timing, dut_b a tiny raster so whole frames fit in a short run.
// Expected pins come from the cycle count since reset release (c): the
// coordinate at cycle k is (k mod H_TOTAL, (k div H_TOTAL) mod V_TOTAL), and
// the pins at c reflect coordinate c-2 with the drawer inputs of cycle c-1.
// -----------------------------------------------------------------------------
module tb_vga_scan_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  red, green, blue;
  logic        drawing;
  logic [11:0] bg;
  logic        tm;

  logic [31:0] pxl_x_a, pxl_y_a, pxl_x_b, pxl_y_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [11:0] rgb_a, rgb_b;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  vga_scan_controller dut_a (
    .clk (clk), .reset (reset), .pxl_x (pxl_x_a), .pxl_y (pxl_y_a),
    .Red_level (red), .Green_level (green), .Blue_level (blue),
    .Drawing (drawing), .bg_rgb (bg),
    .vga_r (r_a), .vga_g (g_a), .vga_b (b_a),
    .hsync (hs_a), .vsync (vs_a), .frame_start (fs_a)
`ifdef VGA_TEST_PATTERN_EN
    , .test_mode (tm)
`endif
  );

  vga_scan_controller #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) dut_b (
    .clk (clk), .reset (reset), .pxl_x (pxl_x_b), .pxl_y (pxl_y_b),
    .Red_level (red), .Green_level (green), .Blue_level (blue),
    .Drawing (drawing), .bg_rgb (bg),
    .vga_r (r_b), .vga_g (g_b), .vga_b (b_b),
    .hsync (hs_b), .vsync (vs_b), .frame_start (fs_b)
`ifdef VGA_TEST_PATTERN_EN
    , .test_mode (tm)
`endif
  );

  // ---------------- reference model ----------------
  longint      c = 0;
  logic        p_drw, p_tm;
  logic [11:0] p_col, p_bg;
  logic [11:0] exp_rgb_a, exp_rgb_b;
  logic        exp_hs_a, exp_vs_a, exp_fs_a, exp_hs_b, exp_vs_b, exp_fs_b;
  int          exp_x_a, exp_y_a;

  function automatic logic [13:0] ref_pins(input longint cc,
      input int ha, input int hfp, input int hsw, input int hbp,
      input int va, input int vfp, input int vsw, input int vbp,
      input logic drw, input logic [11:0] col, input logic [11:0] bgc, input logic tmode);
    int ht, vt, x, y;
    longint k;
    logic act, hsl, vsl;
    logic [11:0] rgb;
    logic [2:0] bar;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (cc < 2) return {1'b1, 1'b1, 12'h000};
    k   = cc - 2;
    x   = int'(k % longint'(ht));
    y   = int'((k / longint'(ht)) % longint'(vt));
    act = (x < ha) && (y < va);
    hsl = !((x >= ha + hfp) && (x < ha + hfp + hsw));
    vsl = !((y >= va + vfp) && (y < va + vfp + vsw));
    if (!act) rgb = 12'h000;
    else if (tmode) begin
      bar = 3'((x / 64) % 8);
      rgb = {bar[2] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[0] ? 4'hF : 4'h0};
    end
    else if (drw) rgb = col;
    else rgb = bgc;
    return {hsl, vsl, rgb};
  endfunction

  function automatic logic ref_fs(input longint cc, input longint period);
    return (cc >= 1) && (((cc - 1) % period) == 0);
  endfunction

  // Advance one clock; leaves time at the following negedge with expectations set.
  task automatic tick();
    p_drw = drawing;
    p_col = {red, green, blue};
    p_bg  = bg;
    p_tm  = tm;
    @(posedge clk);
    if (reset) c = 0;
    else c = c + 1;
    @(negedge clk);
    {exp_hs_a, exp_vs_a, exp_rgb_a} = ref_pins(c, 640, 16, 96, 48, 480, 10, 2, 33, p_drw, p_col, p_bg, p_tm);
    {exp_hs_b, exp_vs_b, exp_rgb_b} = ref_pins(c, 16, 2, 3, 3, 8, 2, 2, 2, p_drw, p_col, p_bg, p_tm);
    exp_fs_a = ref_fs(c, 64'd420000);
    exp_fs_b = ref_fs(c, 64'd336);
    exp_x_a  = int'(c % 800);
    exp_y_a  = int'((c / 800) % 525);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hs_a !== 1'b1 || vs_a !== 1'b1) begin
        errors++; $display("FAIL reset_sync got %b%b want 11", hs_a, vs_a);
      end
      checks++;
      if (rgb_a !== 12'h000) begin
        errors++; $display("FAIL reset_rgb got %h want 000", rgb_a);
      end
      checks++;
      if (fs_a !== 1'b0) begin
        errors++; $display("FAIL reset_fs got %b want 0", fs_a);
      end
    end
    reset = 1'b0;
    checks++;
    if (pxl_x_a !== 32'd0 || pxl_y_a !== 32'd0) begin
      errors++; $display("FAIL release_xy got %0d,%0d want 0,0", pxl_x_a, pxl_y_a);
    end
    checks++;
    if (fs_a !== 1'b0) begin
      errors++; $display("FAIL release_fs0 got %b want 0", fs_a);
    end
    tick();
    checks++;
    if (fs_a !== 1'b1) begin
      errors++; $display("FAIL first_fs got %b want 1", fs_a);
    end
    checks++;
    if (pxl_x_a !== 32'd1) begin
      errors++; $display("FAIL first_x got %0d want 1", pxl_x_a);
    end
    tick();
    checks++;
    if (fs_a !== 1'b0) begin
      errors++; $display("FAIL fs_width got %b want 0", fs_a);
    end
  endtask

  task automatic test_line();
    int falls[$];
    int rises[$];
    logic prev_hs;
    drawing = 1'b0;
    bg = 12'h888;
    prev_hs = hs_a;
    while (c < 1700) begin
      {red, green, blue} = 12'($urandom);
      tick();
      checks++;
      if (hs_a !== exp_hs_a || rgb_a !== exp_rgb_a) begin
        errors++; $display("FAIL line_pins c=%0d got %b/%h want %b/%h", c, hs_a, rgb_a, exp_hs_a, exp_rgb_a);
      end
      checks++;
      if (pxl_x_a !== 32'(exp_x_a) || pxl_y_a !== 32'(exp_y_a)) begin
        errors++; $display("FAIL line_xy c=%0d got %0d,%0d want %0d,%0d", c, pxl_x_a, pxl_y_a, exp_x_a, exp_y_a);
      end
      if (prev_hs === 1'b1 && hs_a === 1'b0) falls.push_back(int'(c));
      if (prev_hs === 1'b0 && hs_a === 1'b1) rises.push_back(int'(c));
      prev_hs = hs_a;
    end
    checks++;
    if (falls.size() != 2 || rises.size() != 2) begin
      errors++; $display("FAIL hsync_edges got %0d/%0d want 2/2", falls.size(), rises.size());
    end else begin
      checks++;
      if (falls[0] != 658) begin
        errors++; $display("FAIL hsync_fall got %0d want 658", falls[0]);
      end
      checks++;
      if (rises[0] - falls[0] != 96) begin
        errors++; $display("FAIL hsync_width got %0d want 96", rises[0] - falls[0]);
      end
      checks++;
      if (falls[1] - falls[0] != 800) begin
        errors++; $display("FAIL hsync_period got %0d want 800", falls[1] - falls[0]);
      end
    end
  endtask

  task automatic test_single_pixel();
    int lx, ly, hits;
    longint hit_c;
    lx = -1; ly = -1; hits = 0; hit_c = -1;
    bg = 12'h888;
    while (c < 40200) begin
      drawing = (lx == 100) && (ly == 50);
      {red, green, blue} = drawing ? 12'hC00 : 12'($urandom);
      lx = int'(pxl_x_a);
      ly = int'(pxl_y_a);
      tick();
      checks++;
      if (rgb_a !== exp_rgb_a) begin
        errors++; $display("FAIL pixel_rgb c=%0d got %h want %h", c, rgb_a, exp_rgb_a);
      end
      if (rgb_a === 12'hC00) begin
        hits++;
        hit_c = c;
      end
    end
    checks++;
    if (hits != 1) begin
      errors++; $display("FAIL pixel_hits got %0d want 1", hits);
    end
    checks++;
    if (hit_c != 40102) begin
      errors++; $display("FAIL pixel_cycle got %0d want 40102", hit_c);
    end
  endtask

  task automatic test_blanking();
    int lx;
    longint stop;
    lx = -1;
    stop = c + 1600;
    while (c < stop) begin
      drawing = (lx >= 640);
      {red, green, blue} = 12'($urandom_range(1, 4095));
      bg = 12'($urandom);
      lx = int'(pxl_x_a);
      tick();
      checks++;
      if (rgb_a !== exp_rgb_a) begin
        errors++; $display("FAIL blank_model c=%0d got %h want %h", c, rgb_a, exp_rgb_a);
      end
      if (p_drw) begin
        checks++;
        if (rgb_a !== 12'h000) begin
          errors++; $display("FAIL blank_black c=%0d got %h want 000", c, rgb_a);
        end
      end
    end
  endtask

  task automatic test_random();
    longint stop;
    stop = c + 2000;
    while (c < stop) begin
      drawing = 1'($urandom);
      {red, green, blue} = 12'($urandom);
      bg = 12'($urandom);
      tick();
      checks++;
      if ({hs_a, vs_a, rgb_a} !== {exp_hs_a, exp_vs_a, exp_rgb_a}) begin
        errors++; $display("FAIL rand_a c=%0d got %b%b/%h want %b%b/%h", c, hs_a, vs_a, rgb_a, exp_hs_a, exp_vs_a, exp_rgb_a);
      end
      checks++;
      if ({hs_b, vs_b, fs_b, rgb_b} !== {exp_hs_b, exp_vs_b, exp_fs_b, exp_rgb_b}) begin
        errors++; $display("FAIL rand_b c=%0d got %b%b%b/%h want %b%b%b/%h", c, hs_b, vs_b, fs_b, rgb_b, exp_hs_b, exp_vs_b, exp_fs_b, exp_rgb_b);
      end
    end
  endtask

  task automatic test_frames();
    longint fs_at[$];
    int lows_per[$];
    int lows;
    longint stop;
    lows = 0;
    drawing = 1'b0;
    stop = c + 3 * 336 + 20;
    while (c < stop) begin
      tick();
      checks++;
      if (vs_b !== exp_vs_b || fs_b !== exp_fs_b) begin
        errors++; $display("FAIL frame_pins c=%0d got %b%b want %b%b", c, vs_b, fs_b, exp_vs_b, exp_fs_b);
      end
      if (fs_b === 1'b1) begin
        if (fs_at.size() > 0) lows_per.push_back(lows);
        lows = 0;
        fs_at.push_back(c);
      end
      if (vs_b === 1'b0) lows++;
    end
    checks++;
    if (fs_at.size() < 3) begin
      errors++; $display("FAIL frame_count got %0d want 3", fs_at.size());
    end else begin
      checks++;
      if (fs_at[1] - fs_at[0] != 336 || fs_at[2] - fs_at[1] != 336) begin
        errors++; $display("FAIL frame_spacing got %0d,%0d want 336", fs_at[1] - fs_at[0], fs_at[2] - fs_at[1]);
      end
      checks++;
      if (lows_per[0] != 48 || lows_per[1] != 48) begin
        errors++; $display("FAIL vsync_width got %0d,%0d want 48", lows_per[0], lows_per[1]);
      end
    end
  endtask

  task automatic test_reset_midline();
    int n;
    n = int'($urandom_range(10, 700));
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (pxl_x_a !== 32'd0 || pxl_y_a !== 32'd0) begin
      errors++; $display("FAIL midreset_xy got %0d,%0d want 0,0", pxl_x_a, pxl_y_a);
    end
    checks++;
    if (hs_a !== 1'b1 || rgb_a !== 12'h000 || fs_a !== 1'b0) begin
      errors++; $display("FAIL midreset_out got %b/%h/%b want 1/000/0", hs_a, rgb_a, fs_a);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (pxl_x_a !== 32'd1 || fs_a !== 1'b1) begin
      errors++; $display("FAIL midreset_restart got x=%0d fs=%b want x=1 fs=1", pxl_x_a, fs_a);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [11:0] want;
    tm = 1'b1;
    while (c < 700) begin
      drawing = 1'($urandom);
      {red, green, blue} = 12'($urandom);
      tick();
      checks++;
      if (rgb_a !== exp_rgb_a) begin
        errors++; $display("FAIL bars_model c=%0d got %h want %h", c, rgb_a, exp_rgb_a);
      end
      want = 12'hBAD;
      if (c == 2 || c == 65) want = 12'h000;
      if (c == 66 || c == 129) want = 12'h00F;
      if (c == 132) want = 12'h0F0;
      if (c == 450 || c == 513) want = 12'hFFF;
      if (c == 514) want = 12'h000;
      if (want != 12'hBAD) begin
        checks++;
        if (rgb_a !== want) begin
          errors++; $display("FAIL bars_fixed x=%0d got %h want %h", c - 2, rgb_a, want);
        end
      end
    end
    tm = 1'b0;
  endtask
`endif

  initial begin
    reset   = 1'b1;
    drawing = 1'b0;
    red     = 4'h0;
    green   = 4'h0;
    blue    = 4'h0;
    bg      = 12'h888;
    tm      = 1'b0;
    test_reset();
    test_line();
    test_single_pixel();
    test_blanking();
    test_random();
    test_frames();
    test_reset_midline();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
